// File: rtl/oram_request_arbiter.sv
// rtl/oram_request_arbiter.sv - two-requester round-robin arbiter in front of an ORAM backend
module oram_request_arbiter #(
    parameter int BECMDWidth  = 2,
    parameter int ORAMU       = 32,
    parameter int FEDWidth    = 64,
    parameter int ORAMB       = 512,
    parameter int Outstanding = 4
) (
    input  logic                          Clock,
    input  logic                          Reset_n,
    input  logic [BECMDWidth-1:0]         R0Command,
    input  logic [ORAMU-1:0]              R0PAddr,
    input  logic                          R0CommandValid,
    output logic                          R0CommandReady,
    input  logic [BECMDWidth-1:0]         R1Command,
    input  logic [ORAMU-1:0]              R1PAddr,
    input  logic                          R1CommandValid,
    output logic                          R1CommandReady,
    input  logic [FEDWidth-1:0]           R0DataIn,
    input  logic                          R0DataInValid,
    output logic                          R0DataInReady,
    input  logic [FEDWidth-1:0]           R1DataIn,
    input  logic                          R1DataInValid,
    output logic                          R1DataInReady,
    output logic [FEDWidth-1:0]           R0DataOut,
    output logic                          R0DataOutValid,
    input  logic                          R0DataOutReady,
    output logic [FEDWidth-1:0]           R1DataOut,
    output logic                          R1DataOutValid,
    input  logic                          R1DataOutReady,
    output logic [BECMDWidth-1:0]         ORAMCommand,
    output logic [ORAMU-1:0]              ORAMPAddr,
    output logic                          ORAMCommandValid,
    input  logic                          ORAMCommandReady,
    output logic [FEDWidth-1:0]           ORAMDataIn,
    output logic                          ORAMDataInValid,
    input  logic                          ORAMDataInReady,
    input  logic [FEDWidth-1:0]           ORAMDataOut,
    input  logic                          ORAMDataOutValid,
    output logic                          ORAMDataOutReady,
    output logic                          Grant,
    output logic                          Busy,
    output logic [$clog2(Outstanding):0]  Pending
);
    localparam int Beats = ORAMB / FEDWidth;
    localparam int BCW   = $clog2(Beats + 1);
    localparam int AW    = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int PW    = $clog2(Outstanding) + 1;
    localparam logic [BCW-1:0]        LAST_BEAT  = BCW'(Beats - 1);
    localparam logic [PW-1:0]         MAX_PEND   = PW'(Outstanding);
    localparam logic [AW-1:0]         LAST_SLOT  = AW'(Outstanding - 1);
    localparam logic [BECMDWidth-1:0] CMD_APPEND = BECMDWidth'(1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA} state_t;

    state_t                state;
    logic [BECMDWidth-1:0] cmd_q;
    logic [ORAMU-1:0]      addr_q;
    logic                  winner;
    logic [BCW-1:0]        wr_beat;
    logic [BCW-1:0]        rd_beat;
    logic                  tag_mem [Outstanding];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;

    logic read_room, elig0, elig1, pick;
    logic cmd_fire, din_fire, dout_fire, in_wdata;
    logic tag_valid, head, push, pop;

    // Update and Append carry a write burst; Read and ReadRmv return one.
    function automatic logic is_write(input logic [BECMDWidth-1:0] c);
        return c <= CMD_APPEND;
    endfunction

    function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    assign read_room = Pending < MAX_PEND;
    assign elig0     = R0CommandValid && (is_write(R0Command) || read_room);
    assign elig1     = R1CommandValid && (is_write(R1Command) || read_room);
    assign pick      = (elig0 && elig1) ? ~Grant : elig1;

    assign ORAMCommandValid = (state == CMD);
    assign ORAMCommand      = cmd_q;
    assign ORAMPAddr        = addr_q;
    assign cmd_fire         = ORAMCommandValid && ORAMCommandReady;
    assign R0CommandReady   = cmd_fire && !winner;
    assign R1CommandReady   = cmd_fire && winner;

    assign in_wdata        = (state == WDATA);
    assign ORAMDataIn      = winner ? R1DataIn : R0DataIn;
    assign ORAMDataInValid = in_wdata && (winner ? R1DataInValid : R0DataInValid);
    assign R0DataInReady   = in_wdata && !winner && ORAMDataInReady;
    assign R1DataInReady   = in_wdata && winner && ORAMDataInReady;
    assign din_fire        = ORAMDataInValid && ORAMDataInReady;

    // Return data is steered purely by the oldest outstanding tag.
    assign tag_valid        = (Pending != '0);
    assign head             = tag_mem[rd_ptr];
    assign R0DataOut        = ORAMDataOut;
    assign R1DataOut        = ORAMDataOut;
    assign R0DataOutValid   = tag_valid && !head && ORAMDataOutValid;
    assign R1DataOutValid   = tag_valid && head && ORAMDataOutValid;
    assign ORAMDataOutReady = tag_valid && (head ? R1DataOutReady : R0DataOutReady);
    assign dout_fire        = ORAMDataOutValid && ORAMDataOutReady;

    assign push = cmd_fire && !is_write(cmd_q);
    assign pop  = dout_fire && (rd_beat == LAST_BEAT);
    assign Busy = (state != IDLE) || tag_valid;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state   <= IDLE;
            Grant   <= 1'b1;
            winner  <= 1'b0;
            cmd_q   <= '0;
            addr_q  <= '0;
            wr_beat <= '0;
            rd_beat <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            Pending <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 || elig1) begin
                        winner <= pick;
                        cmd_q  <= pick ? R1Command : R0Command;
                        addr_q <= pick ? R1PAddr : R0PAddr;
                        state  <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_fire) begin
                        Grant   <= winner;
                        wr_beat <= '0;
                        state   <= is_write(cmd_q) ? WDATA : IDLE;
                    end
                end
                WDATA: begin
                    if (din_fire) begin
                        if (wr_beat == LAST_BEAT) begin
                            wr_beat <= '0;
                            state   <= IDLE;
                        end else begin
                            wr_beat <= wr_beat + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (push) wr_ptr <= next_slot(wr_ptr);
            if (pop) rd_ptr <= next_slot(rd_ptr);
            if (dout_fire) rd_beat <= pop ? '0 : rd_beat + 1'b1;
            if (push && !pop) Pending <= Pending + 1'b1;
            else if (pop && !push) Pending <= Pending - 1'b1;
        end
    end

    // Tag storage needs no reset: entries are only read behind a nonzero Pending.
    always_ff @(posedge Clock) begin
        if (push) tag_mem[wr_ptr] <= winner;
    end
endmodule

// File: tb/tb_oram_request_arbiter.sv
// tb/tb_oram_request_arbiter.sv - randomized scoreboard bench for oram_request_arbiter
module tb_oram_request_arbiter;
    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
    } cmd_t;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [1:0]  R0Command = '0, R1Command = '0;
    logic [31:0] R0PAddr = '0, R1PAddr = '0;
    logic        R0CommandValid = 1'b0, R1CommandValid = 1'b0;
    logic        R0CommandReady, R1CommandReady;
    logic [63:0] R0DataIn = '0, R1DataIn = '0;
    logic        R0DataInValid = 1'b0, R1DataInValid = 1'b0;
    logic        R0DataInReady, R1DataInReady;
    logic [63:0] R0DataOut, R1DataOut;
    logic        R0DataOutValid, R1DataOutValid;
    logic        R0DataOutReady = 1'b0, R1DataOutReady = 1'b0;
    logic [1:0]  ORAMCommand;
    logic [31:0] ORAMPAddr;
    logic        ORAMCommandValid;
    logic        ORAMCommandReady = 1'b0;
    logic [63:0] ORAMDataIn;
    logic        ORAMDataInValid;
    logic        ORAMDataInReady = 1'b0;
    logic [63:0] ORAMDataOut = '0;
    logic        ORAMDataOutValid = 1'b0;
    logic        ORAMDataOutReady;
    logic        Grant, Busy;
    logic [2:0]  Pending;

    always #5 Clock = ~Clock;

    oram_request_arbiter dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .R0Command(R0Command), .R0PAddr(R0PAddr), .R0CommandValid(R0CommandValid), .R0CommandReady(R0CommandReady),
        .R1Command(R1Command), .R1PAddr(R1PAddr), .R1CommandValid(R1CommandValid), .R1CommandReady(R1CommandReady),
        .R0DataIn(R0DataIn), .R0DataInValid(R0DataInValid), .R0DataInReady(R0DataInReady),
        .R1DataIn(R1DataIn), .R1DataInValid(R1DataInValid), .R1DataInReady(R1DataInReady),
        .R0DataOut(R0DataOut), .R0DataOutValid(R0DataOutValid), .R0DataOutReady(R0DataOutReady),
        .R1DataOut(R1DataOut), .R1DataOutValid(R1DataOutValid), .R1DataOutReady(R1DataOutReady),
        .ORAMCommand(ORAMCommand), .ORAMPAddr(ORAMPAddr), .ORAMCommandValid(ORAMCommandValid),
        .ORAMCommandReady(ORAMCommandReady),
        .ORAMDataIn(ORAMDataIn), .ORAMDataInValid(ORAMDataInValid), .ORAMDataInReady(ORAMDataInReady),
        .ORAMDataOut(ORAMDataOut), .ORAMDataOutValid(ORAMDataOutValid), .ORAMDataOutReady(ORAMDataOutReady),
        .Grant(Grant), .Busy(Busy), .Pending(Pending)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: requester command queues, active write burst, read tags and return beats.
    cmd_t        cq0[$], cq1[$];
    logic        tags[$];
    logic [63:0] ret_q[$];
    logic        grant_log[$];
    bit          wr_active = 0;
    logic        wr_owner = 0;
    logic [31:0] wr_addr = '0;
    int          wr_beat = 0;
    int          ret_beat = 0;
    int          beats_fwd = 0;
    logic        exp_grant = 1'b1;

    bit gen_en = 0, din_toggle = 0, expect_quiet = 0;
    int p_cmd_rdy = 100, p_din_vld = 100, p_din_rdy = 100, p_dout_vld = 100, p_dout_rdy = 100;
    int ret_budget = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [31:0] a, input int b);
        return {a, 29'h0, 3'(b)};
    endfunction

    function automatic bit model_idle();
        return cq0.size() == 0 && cq1.size() == 0 && tags.size() == 0 && !wr_active;
    endfunction

    function automatic bit rnd(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic step(input bit do_rst);
        logic own, h, w_vld;
        cmd_t hd;
        @(negedge Clock);
        Reset_n = !do_rst;
        if (gen_en) begin
            if (cq0.size() == 0 && rnd(30)) cq0.push_back({2'($urandom_range(3)), 1'b0, 27'($urandom), 4'h0});
            if (cq1.size() == 0 && rnd(30)) cq1.push_back({2'($urandom_range(3)), 1'b1, 27'($urandom), 4'h0});
        end
        R0CommandValid = cq0.size() != 0;
        {R0Command, R0PAddr} = (cq0.size() != 0) ? cq0[0] : '0;
        R1CommandValid = cq1.size() != 0;
        {R1Command, R1PAddr} = (cq1.size() != 0) ? cq1[0] : '0;
        R0DataInValid = wr_active && !wr_owner && rnd(p_din_vld);
        R1DataInValid = wr_active && wr_owner && rnd(p_din_vld);
        R0DataIn = wr_owner ? 64'($urandom) : pat(wr_addr, wr_beat);
        R1DataIn = wr_owner ? pat(wr_addr, wr_beat) : 64'($urandom);
        ORAMCommandReady = rnd(p_cmd_rdy);
        ORAMDataInReady = din_toggle ? !ORAMDataInReady : rnd(p_din_rdy);
        if (ret_q.size() == 0) begin
            ORAMDataOutValid = rnd(50);
            ORAMDataOut = {$urandom, $urandom};
        end else begin
            ORAMDataOutValid = (ret_budget != 0) && rnd(p_dout_vld);
            ORAMDataOut = ret_q[0];
        end
        R0DataOutReady = rnd(p_dout_rdy);
        R1DataOutReady = rnd(p_dout_rdy);
        #1;
        if (do_rst) begin
            cq0.delete(); cq1.delete(); tags.delete(); ret_q.delete();
            wr_active = 0; ret_beat = 0; exp_grant = 1'b1;
            return;
        end

        check("pending", 64'(Pending), 64'(tags.size()));
        check("grant", 64'(Grant), 64'(exp_grant));
        if (tags.size() != 0) check("busy_pending", 64'(Busy), 64'd1);
        if (expect_quiet) begin
            check("quiet_cmd_valid", 64'(ORAMCommandValid), 64'd0);
            check("quiet_busy", 64'(Busy), 64'd0);
        end

        // Write-data channel.
        if (!wr_active) begin
            check("din_valid_idle", 64'(ORAMDataInValid), 64'd0);
            check("din_ready_idle", 64'({R1DataInReady, R0DataInReady}), 64'd0);
        end else begin
            w_vld = wr_owner ? R1DataInValid : R0DataInValid;
            check("din_valid", 64'(ORAMDataInValid), 64'(w_vld));
            check("din_ready", 64'({R1DataInReady, R0DataInReady}),
                  ORAMDataInReady ? (wr_owner ? 64'd2 : 64'd1) : 64'd0);
            if (ORAMDataInValid && ORAMDataInReady) begin
                check("din_data", ORAMDataIn, pat(wr_addr, wr_beat));
                wr_beat++;
                beats_fwd++;
                if (wr_beat == 8) wr_active = 0;
            end
        end

        // Read-return channel.
        if (tags.size() == 0) begin
            check("dout_ready_empty", 64'(ORAMDataOutReady), 64'd0);
            check("dout_valid_empty", 64'({R1DataOutValid, R0DataOutValid}), 64'd0);
        end else begin
            h = tags[0];
            check("dout_valid", 64'({R1DataOutValid, R0DataOutValid}),
                  ORAMDataOutValid ? (h ? 64'd2 : 64'd1) : 64'd0);
            check("dout_ready", 64'(ORAMDataOutReady), 64'(h ? R1DataOutReady : R0DataOutReady));
            if (ORAMDataOutValid && ORAMDataOutReady) begin
                check("dout_data", h ? R1DataOut : R0DataOut, ret_q[0]);
                void'(ret_q.pop_front());
                if (ret_budget > 0) ret_budget--;
                ret_beat++;
                if (ret_beat == 8) begin
                    ret_beat = 0;
                    void'(tags.pop_front());
                end
            end
        end

        // Command channel; the address MSB identifies the issuing requester.
        if (ORAMCommandValid && ORAMCommandReady) begin
            own = ORAMPAddr[31];
            check("cmd_ready_route", 64'({R1CommandReady, R0CommandReady}), own ? 64'd2 : 64'd1);
            check("cmd_has_request", 64'((own ? cq1.size() : cq0.size()) != 0), 64'd1);
            if ((own ? cq1.size() : cq0.size()) != 0) begin
                hd = own ? cq1[0] : cq0[0];
                check("cmd_fields", 64'({ORAMCommand, ORAMPAddr}), 64'(hd));
                if (own) void'(cq1.pop_front());
                else void'(cq0.pop_front());
                grant_log.push_back(own);
                exp_grant = own;
                if (hd.cmd <= 2'd1) begin
                    wr_active = 1; wr_owner = own; wr_addr = hd.addr; wr_beat = 0;
                end else begin
                    check("read_limit", 64'(tags.size() < 4), 64'd1);
                    tags.push_back(own);
                    repeat (8) ret_q.push_back({$urandom, $urandom});
                end
            end
        end else begin
            check("cmd_ready_idle", 64'({R1CommandReady, R0CommandReady}), 64'd0);
        end
    endtask

    initial begin
        step(1);
        step(1);
        expect_quiet = 1;
        repeat (4) step(0);
        expect_quiet = 0;

        // Both requesters stream reads: grants alternate starting at requester 0.
        ret_budget = 0;
        cq0.push_back({2'd2, 32'h0000_0100}); cq0.push_back({2'd3, 32'h0000_0200});
        cq1.push_back({2'd2, 32'h8000_0100}); cq1.push_back({2'd2, 32'h8000_0200});
        grant_log.delete();
        for (int i = 0; i < 60 && (cq0.size() != 0 || cq1.size() != 0); i++) step(0);
        check("rr_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4)
            check("rr_order", 64'({grant_log[3], grant_log[2], grant_log[1], grant_log[0]}), 64'b1010);
        step(0);
        check("pending_full", 64'(Pending), 64'd4);

        // Fifth read stalls while a write is still granted.
        cq1.push_back({2'd2, 32'h8000_0300});
        repeat (20) step(0);
        check("read_stalled", 64'(cq1.size()), 64'd1);
        cq0.push_back({2'd0, 32'h0000_0010});
        din_toggle = 1;
        beats_fwd = 0;
        for (int i = 0; i < 80 && (cq0.size() != 0 || wr_active); i++) step(0);
        check("write_beats", 64'(beats_fwd), 64'd8);
        check("read_still_stalled", 64'(cq1.size()), 64'd1);
        din_toggle = 0;

        // One burst returned frees a slot for the stalled read.
        ret_budget = 8;
        for (int i = 0; i < 60 && cq1.size() != 0; i++) step(0);
        check("read_resumed", 64'(cq1.size()), 64'd0);
        step(0);
        check("pending_refilled", 64'(Pending), 64'd4);
        ret_budget = -1;
        for (int i = 0; i < 300 && !model_idle(); i++) step(0);
        check("drain_directed", 64'(model_idle()), 64'd1);

        // Reset in the middle of a write burst.
        cq0.push_back({2'd1, 32'h0000_0020});
        for (int i = 0; i < 40 && !(wr_active && wr_beat == 4); i++) step(0);
        check("reached_beat4", 64'(wr_active && wr_beat == 4), 64'd1);
        step(1);
        expect_quiet = 1;
        repeat (2) step(0);
        expect_quiet = 0;
        grant_log.delete();
        cq1.push_back({2'd2, 32'h8000_0040});
        for (int i = 0; i < 20 && cq1.size() != 0; i++) step(0);
        check("post_reset_read", 64'(grant_log.size()), 64'd1);
        for (int i = 0; i < 100 && !model_idle(); i++) step(0);

        // Random traffic with backpressure on every channel.
        gen_en = 1;
        p_cmd_rdy = 60; p_din_vld = 70; p_din_rdy = 60; p_dout_vld = 70; p_dout_rdy = 60;
        repeat (4000) step(0);
        gen_en = 0;
        for (int i = 0; i < 3000 && !model_idle(); i++) step(0);
        check("drain_random", 64'(model_idle()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/oram_request_arbiter.md
ORAM_REQUEST_ARBITER -- requirements
Module: oram_request_arbiter

Interface
REQ-001 SHALL have parameter BECMDWidth, default 2, backend command width; encodings Update=0, Append=1, Read=2, ReadRmv=3.
REQ-002 SHALL have parameter ORAMU, default 32, physical address width.
REQ-003 SHALL have parameter FEDWidth, default 64, data beat width.
REQ-004 SHALL have parameter ORAMB, default 512, block width; Beats = ORAMB/FEDWidth, default 8.
REQ-005 SHALL have parameter Outstanding, default 4, maximum in-flight reads; must be a power of two.
REQ-006 SHALL have port Clock  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port Reset_n  in  1  synchronous, active-low reset.
REQ-008 SHALL have ports R0Command/R1Command  in  BECMDWidth, R0PAddr/R1PAddr  in  ORAMU, R{0,1}CommandValid  in  1, R{0,1}CommandReady  out  1; requester command channels.
REQ-009 SHALL have ports R{0,1}DataIn  in  FEDWidth, R{0,1}DataInValid  in  1, R{0,1}DataInReady  out  1; requester write data.
REQ-010 SHALL have ports R{0,1}DataOut  out  FEDWidth, R{0,1}DataOutValid  out  1, R{0,1}DataOutReady  in  1; requester read return.
REQ-011 SHALL have ports ORAMCommand  out  BECMDWidth, ORAMPAddr  out  ORAMU, ORAMCommandValid  out  1, ORAMCommandReady  in  1; frontend command.
REQ-012 SHALL have ports ORAMDataIn  out  FEDWidth, ORAMDataInValid  out  1, ORAMDataInReady  in  1; frontend write data.
REQ-013 SHALL have ports ORAMDataOut  in  FEDWidth, ORAMDataOutValid  in  1, ORAMDataOutReady  out  1; frontend read data.
REQ-014 SHALL have ports Grant  out  1 (last granted requester), Busy  out  1 (state != Idle or reads outstanding), Pending  out  log2(Outstanding)+1 (in-flight read count).

Function
REQ-015 SHALL implement states Idle, Cmd, WData; all transfers are valid&ready handshakes; no combinational path from any Ready input to a Valid output on the same channel.
REQ-016 Idle: among eligible requesters (CommandValid high; reads eligible only when Pending < Outstanding), SHALL pick round-robin, preferring the requester not equal to Grant; latch command, address and winner; go to Cmd next cycle.
REQ-017 Cmd: SHALL drive the latched command/address with ORAMCommandValid=1 and SHALL assert the winner's CommandReady only in the cycle the ORAM command transfers (pass-through handshake).
REQ-018 On command transfer: write (Update/Append) -> WData; read -> push winner ID into return-tag FIFO, go Idle.
REQ-019 WData: SHALL connect winner DataIn/Valid to ORAM DataIn/Valid and ORAMDataInReady to winner DataInReady; the other requester's DataInReady stays 0; count beats; Idle after beat Beats transfers.
REQ-020 Grant SHALL update only on command transfer; first arbitration after reset favours requester 0.
REQ-021 Return path: while the tag FIFO is non-empty, SHALL route ORAMDataOut/Valid to the head requester, ORAMDataOutReady = that requester's DataOutReady; non-head DataOutValid = 0.
REQ-022 SHALL count return beats; pop the tag after the Beats-th beat; beat counter wraps to 0.
REQ-023 With the tag FIFO empty, ORAMDataOutReady SHALL be 0 (data held upstream).
REQ-024 Pending SHALL equal pushes minus pops; simultaneous push and pop leaves it unchanged.
REQ-025 With Pending == Outstanding, reads SHALL stall in Idle while writes remain grantable.
REQ-026 Command issue and read return SHALL proceed concurrently and independently.

Reset
REQ-027 With Reset_n low at a clock edge: state=Idle, Grant=1 (so requester 0 is favoured first), Pending=0, beat counters=0, tag FIFO empty; all Valid/Ready outputs 0 the following cycle, overriding any mid-burst transfer.
REQ-028 Partially transferred write or read bursts SHALL be discarded on reset; no recovery.

Verification
REQ-029 Both requesters hold Read valid continuously, ORAM always ready -> grants alternate 0,1,0,1; tags return data beats 8/8 to matching requester.
REQ-030 R0 Update addr 0x10 with 8 beats, ORAMDataInReady toggling every cycle -> exactly 8 beats forwarded, R1DataInReady=0 throughout, then Idle.
REQ-031 R1 issues 5 reads with no return data -> 4 issued, Pending=4, 5th stalls; R0 Update still granted; after one 8-beat return, Pending=3 and 5th read issues.
REQ-032 ORAMDataOutValid high with empty tag FIFO -> ORAMDataOutReady=0, no R{0,1}DataOutValid.
REQ-033 R0DataOutReady held 0 mid-return at beat 3 -> ORAMDataOutReady=0, beat counter holds at 3, resumes without loss.
REQ-034 Reset_n low during WData beat 4 -> next cycle Idle, Pending=0, all Valid outputs 0; subsequent R1 Read granted normally.
